// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - master, arbiter and data-memory signal bundle for dmem_arbiter
`timescale 1ns/1ps
interface dmem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output CS, DM_R, DM_W, addr, data_w,
        input  data_r
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  CS, DM_R, DM_W, addr, data_w,
        output data_r
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-master sequencer for the single-port data memory
// Optional address bounds check enabled by defining DMEM_ARB_BOUNDS_EN.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic           inclk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic        rej_q, rej_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        grant;
    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_rej;
    logic        cs;
    logic [31:0] cap;

    // In DONE only the port that was not just served may chain straight into ACCESS.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    grant = 1'b1;
                    win   = ~last_q;
                end else if (bus.m0_req) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (bus.m1_req) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
            end
            DONE: begin
                if (owner_q ? bus.m0_req : bus.m1_req) begin
                    grant = 1'b1;
                    win   = ~owner_q;
                end
            end
            default: ;
        endcase
    end

    assign sel_we    = win ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    assign sel_rej   = BoundsEn && ({2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS));

    assign cs  = (state_q == ACCESS) && !rej_q;
    assign cap = (we_q || rej_q) ? 32'h0 : bus.data_r;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        rej_d    = rej_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE, DONE: begin
                if (grant) begin
                    state_d = ACCESS;
                    owner_d = win;
                    last_d  = win;
                    we_d    = sel_we;
                    rej_d   = sel_rej;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (owner_q) rdata1_d = cap;
                else         rdata0_d = cap;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b1;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            rej_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            rej_q    <= rej_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.CS     = cs;
    assign bus.DM_R   = cs && !we_q;
    assign bus.DM_W   = cs && we_q;
    assign bus.addr   = addr_q;
    assign bus.data_w = wdata_q;

    assign bus.m0_ack   = (state_q == DONE) && !owner_q;
    assign bus.m1_ack   = (state_q == DONE) && owner_q;
    assign bus.m0_err   = bus.m0_ack && rej_q;
    assign bus.m1_err   = bus.m1_ack && rej_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a shadow memory
`timescale 1ns/1ps
module tb_dmem_arbiter;
    logic inclk = 1'b0;
    logic rst_n = 1'b0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_WORDS(1024)) dut (
        .inclk (inclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 inclk = ~inclk;

    bit [31:0] mem     [1024];
    bit        mem_wr  [1024];
    bit [31:0] shadow  [1024];
    bit        sh_wr   [1024];

    function automatic logic [31:0] init_val(input logic [9:0] i);
        return (i == 10'd2) ? 32'h12345678 : {16'hC0DE, 6'b0, i};
    endfunction

    always @(posedge inclk) begin
        if (bus.DM_W) begin
            mem[bus.addr[11:2]]    <= bus.data_w;
            mem_wr[bus.addr[11:2]] <= 1'b1;
        end
    end

    assign bus.data_r = mem_wr[bus.addr[11:2]] ? mem[bus.addr[11:2]] : init_val(bus.addr[11:2]);

    function automatic logic [31:0] sh_rd(input logic [9:0] i);
        return sh_wr[i] ? shadow[i] : init_val(i);
    endfunction

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge inclk);
    endtask

    function automatic logic ack_of(input bit p);
        return p ? bus.m1_ack : bus.m0_ack;
    endfunction

    function automatic logic err_of(input bit p);
        return p ? bus.m1_err : bus.m0_err;
    endfunction

    function automatic logic [31:0] rd_of(input bit p);
        return p ? bus.m1_rdata : bus.m0_rdata;
    endfunction

    task automatic drive(input bit p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd;
        end else begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},     {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h0);
        chk({tag, "_addr"},   bus.addr, 32'h0);
        chk({tag, "_data_w"}, bus.data_w, 32'h0);
        chk({tag, "_ackerr"}, {28'b0, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 32'h0);
        chk({tag, "_rd0"},    bus.m0_rdata, 32'h0);
        chk({tag, "_rd1"},    bus.m1_rdata, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        drive(p, 1'b1, we, a, wd);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ack_of(p) && lat < 10);
        rd  = rd_of(p);
        err = err_of(p);
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nacks;
    int          last_cyc;
    bit          pend [2];
    int          gap  [2];
    int          wt   [2];
    bit          rwe  [2];
    logic [31:0] radr [2];
    logic [31:0] rwd  [2];

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Reset asserted in the middle of an M0 write must block the commit.
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(posedge inclk);
        #2;
        chk("midrst_pre_cs", {31'b0, bus.DM_W}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        access(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("midrst_read", rd, init_val(10'd4));
        chk("midrst_lat", lat, 2);

        // Single read with cycle-by-cycle enables.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        step();
        chk("rd_access_en", {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h6);
        chk("rd_access_addr", bus.addr, 32'h8);
        chk("rd_access_ack", {31'b0, bus.m0_ack}, 32'h0);
        step();
        chk("rd_done_ack", {30'b0, bus.m0_ack, bus.m1_ack}, 32'h2);
        chk("rd_done_data", bus.m0_rdata, 32'h12345678);
        chk("rd_done_en", {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("rd_idle_ack", {31'b0, bus.m0_ack}, 32'h0);
        chk("rd_idle_en", {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h0);

        // M1 write then read back; M0 side untouched.
        do_reset();
        access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, rd, er, lat);
        shadow[16] = 32'hA5A5A5A5;
        sh_wr[16]  = 1'b1;
        chk("m1_wr_lat", lat, 2);
        chk("m1_wr_rdata", rd, 32'h0);
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("m1_rd_data", rd, 32'hA5A5A5A5);
        chk("m1_rd_err", {31'b0, er}, 32'h0);
        chk("m1_m0_rdata", bus.m0_rdata, 32'h0);
        chk("m1_m0_ack", {31'b0, bus.m0_ack}, 32'h0);

        // Both masters held high: strict alternation starting with M0, ack every 2 cycles.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        nacks = 0;
        for (int c = 1; c <= 40 && nacks < 8; c++) begin
            step();
            chk("cont_dual_ack", {31'b0, bus.m0_ack & bus.m1_ack}, 32'h0);
            if (bus.m0_ack || bus.m1_ack) begin
                chk("cont_order", {31'b0, bus.m1_ack}, 32'(nacks % 2));
                chk("cont_cycle", c, 2 * (nacks + 1));
                chk("cont_data", bus.m1_ack ? bus.m1_rdata : bus.m0_rdata,
                    bus.m1_ack ? 32'hA5A5A5A5 : 32'h12345678);
                nacks++;
            end
        end
        chk("cont_count", nacks, 8);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Out-of-range write at 0x1000.
        drive(1'b0, 1'b1, 1'b1, 32'h1000, 32'h77777777);
        step();
`ifdef DMEM_ARB_BOUNDS_EN
        chk("bnd_en", {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h0);
`else
        chk("bnd_en", {29'b0, bus.CS, bus.DM_R, bus.DM_W}, 32'h5);
        shadow[0] = 32'h77777777;
        sh_wr[0]  = 1'b1;
`endif
        step();
        chk("bnd_ack", {31'b0, bus.m0_ack}, 32'h1);
`ifdef DMEM_ARB_BOUNDS_EN
        chk("bnd_err", {31'b0, bus.m0_err}, 32'h1);
`else
        chk("bnd_err", {31'b0, bus.m0_err}, 32'h0);
`endif
        chk("bnd_rdata", bus.m0_rdata, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("bnd_err_after", {31'b0, bus.m0_err}, 32'h0);
        access(1'b0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        chk("bnd_word0", rd, sh_rd(10'd0));

        // Owner keeps req high through DONE: served again via IDLE, ack every 3 cycles.
        drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        nacks = 0;
        for (int c = 1; c <= 20 && nacks < 3; c++) begin
            step();
            if (bus.m0_ack) begin
                chk("rereq_cycle", c, 2 + 3 * nacks);
                nacks++;
            end
        end
        chk("rereq_count", nacks, 3);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Randomized traffic from both masters against the shadow memory, serialised in ack order.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            gap[p]  = 0;
            wt[p]   = 0;
        end
        for (int c = 0; c < 600; c++) begin
            step();
            if (bus.m0_ack || bus.m1_ack)
                chk("rnd_dual_ack", {31'b0, bus.m0_ack & bus.m1_ack}, 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p[0])) begin
                    chk("rnd_ack_pending", {31'b0, pend[p]}, 32'h1);
                    chk("rnd_err", {31'b0, err_of(p[0])}, 32'h0);
                    if (rwe[p]) begin
                        chk("rnd_wr_rdata", rd_of(p[0]), 32'h0);
                        shadow[radr[p][11:2]] = rwd[p];
                        sh_wr[radr[p][11:2]]  = 1'b1;
                    end else begin
                        chk("rnd_rd_data", rd_of(p[0]), sh_rd(radr[p][11:2]));
                    end
                    pend[p] = 1'b0;
                    gap[p]  = int'($urandom_range(1, 4));
                    drive(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
                end else if (pend[p]) begin
                    wt[p]++;
                    if (wt[p] > 12) begin
                        chk("rnd_timeout", wt[p], 12);
                        pend[p] = 1'b0;
                        gap[p]  = 2;
                        drive(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if ($urandom_range(0, 1) == 1) begin
                    rwe[p]  = $urandom_range(0, 1) == 1;
                    radr[p] = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                    rwd[p]  = $urandom;
                    pend[p] = 1'b1;
                    wt[p]   = 0;
                    drive(p[0], 1'b1, rwe[p], radr[p], rwd[p]);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory. It shares the memory between the CPU load/store port (M0) and an auxiliary master port (M1, used for debug and loader access) using round-robin priority. It drives the memory's chip-select, read/write enables, address and write data, and returns captured read data with a one-cycle acknowledge. It sits between the masters and the data memory; the memory read path is combinational and its write commits on the rising clock edge.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; used only by the bounds check.
- inclk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request; held high until m0_ack.
- m0_we  in  1  M0 access type: 1 = write, 0 = read.
- m0_addr  in  32  M0 byte address.
- m0_wdata  in  32  M0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  32  captured read data; valid while m0_ack is high.
- m0_err  out  1  out-of-range flag; valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as the M0 ports, for M1.
- CS  out  1  memory chip select.
- DM_R  out  1  memory read enable.
- DM_W  out  1  memory write enable.
- addr  out  32  memory address.
- data_w  out  32  memory write data.
- data_r  in  32  memory read data (combinational).

## Operation
- FSM states:
  - IDLE.
  - ACCESS: the memory cycle.
  - DONE: acknowledge cycle.
- IDLE:
  - If any request is high, arbitrate.
  - Register the winner into owner, along with its we, addr and wdata.
  - Go to ACCESS.
- ACCESS:
  - Memory outputs are driven from the latched registers.
  - CS is 1 unless the access is rejected by the bounds check.
  - DM_R is the inverse of the latched we, and DM_W is the latched we; both are gated by CS.
  - data_r is captured into the owner's rdata register, or 0 for writes and rejected accesses.
  - Go to DONE.
- DONE:
  - The owner's ack is 1 for this one cycle.
  - Only the non-owner's request is considered.
    - If it is high, latch it and go directly to ACCESS (back-to-back transfer).
    - Otherwise go to IDLE.
- Owner request sampled in DONE: ignored. The master must deassert req in the cycle after ack, or re-request from IDLE.
- Round-robin:
  - The last register holds the most recently served port; it updates when ACCESS is entered.
  - On a simultaneous request, the port that is not last wins.
  - A single requester always wins.
  - last resets to 1, so M0 wins the first tie.
- In IDLE and DONE, CS, DM_R and DM_W are 0. addr and data_w hold their latched values.
- Non-owner outputs: ack is 0 and err is 0; rdata holds its last captured value.
- addr[1:0] passes through unchanged; it is not checked for alignment.

## Timing
- Reset (asynchronous, immediate):
  - State is IDLE; owner and last are 1.
  - All outputs are 0, including both rdata buses.
  - Memory enables are low, so a write in flight at reset assertion does not commit.
- Access latency:
  - Request sampled at edge E0 (state was IDLE).
  - ACCESS runs in cycle E0..E1; the write commits and read data is captured at E1.
  - ack is high in cycle E1..E2.
- Throughput:
  - Alternating masters: one access per 2 cycles.
  - A single master: one access per 3 cycles.
- A request dropped before ack while in IDLE: not latched.
- A request dropped after latching: the access still completes.
- Both requests high continuously: grants alternate M0, M1, M0, ...

## Configuration
- DMEM_ARB_BOUNDS_EN defined:
  - At latch time, a latched addr[31:2] >= MEM_WORDS marks the access rejected.
  - In ACCESS, a rejected access has CS = 0, no write commits, and rdata is captured as 0.
  - err is 1 together with ack.
- DMEM_ARB_BOUNDS_EN undefined:
  - No check; err is tied to 0.
  - Every access asserts CS, and the address passes through unchanged.

## Test plan
- Reset: assert rst_n = 0 mid-ACCESS of an M0 write of 0xDEADBEEF to 0x10 -> outputs are 0 immediately; read 0x10 afterwards -> the old value, not 0xDEADBEEF.
- Single read: M0 reads 0x8 holding 0x12345678 -> ack 2 cycles after the request edge, m0_rdata = 0x12345678, CS/DM_R high exactly one cycle.
- Write then read: M1 writes 0xA5A5A5A5 to 0x40, then reads 0x40 -> m1_rdata = 0xA5A5A5A5; M0 outputs stay 0.
- Contention: both requesters held high for 8 accesses from reset -> order M0, M1, M0, M1, ...; back-to-back with ACCESS every 2 cycles, and no cycle with two acks.
- Bounds (macro defined): M0 writes to 0x1000 with MEM_WORDS = 1024 -> CS stays 0, m0_err = 1 with ack, m0_rdata = 0; macro undefined -> CS = 1, err = 0.
- Owner re-request: M0 keeps req high through DONE while M1 is idle -> arbiter goes to IDLE and serves M0 again, ack every 3 cycles.
